mcycle_unit: RTL and testbench
==============================

// Module: mcycle_unit
// PURPOSE
//   Iterative multiply/divide engine in the EX stage. Produces M_BusyE, M_DoneE and WA3R for the hazard unit.
//   Takes one MUL/DIV per Start pulse. Computes over WIDTH cycles while younger independent instructions keep flowing.
//   Raises Done for one cycle so the pipeline stalls and the result is written back through the E-stage result mux.
// PARAMETERS
//   WIDTH   32   operand width in bits; also the iteration count
// PORTS
//   CLK        in   1      single clock; all state updates on rising edge
//   RESETn     in   1      asynchronous, active-low reset
//   Start      in   1      request from E stage (M_StartE); sampled only in IDLE
//   MCycleOp   in   2      [0]: 0=MUL, 1=DIV; [1]: 0=signed, 1=unsigned
//   Operand1   in   WIDTH  multiplicand / dividend
//   Operand2   in   WIDTH  multiplier / divisor
//   WA3E       in   4      destination register of the requesting instruction
//   Busy       out  1      iteration in progress (to M_BusyE)
//   Done       out  1      one-cycle pulse; Result1/Result2 valid (to M_DoneE)
//   WA3R       out  4      destination of the in-flight/last op (to hazard unit)
//   Result1    out  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
//   Result2    out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
// BEHAVIOUR
//   - Reset (async, RESETn=0): state=IDLE; Busy=0, Done=0, WA3R=0, Result1=Result2=0, iteration counter=0.
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE:
//       - Start=1 is accepted. Operands (as magnitudes if signed), the result signs, MCycleOp and WA3E are latched.
//       - WA3R<=WA3E, counter<=0. Next state is RUN.
//       - DIV with Operand2==0 goes straight to DONE instead.
//   - RUN:
//       - Busy=1. One shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle. counter++.
//       - At counter==WIDTH-1 the step completes, the sign fix is applied and Result1/2 are loaded. Next state is DONE.
//   - DONE: Done=1, Busy=0 for exactly one cycle, then IDLE.
//   - Latency: Start accepted in cycle 0 -> Busy in cycles 1..WIDTH -> Done in cycle WIDTH+1.
//   - Results and WA3R hold their values until the next accepted Start; they do not clear on IDLE.
//   - Start while Busy=1 or Done=1 is ignored; no queueing. The hazard unit holds the request stalled and it is re-sampled in IDLE.
//   - Operands are sampled only at acceptance; input changes during RUN have no effect.
//   - Signed MUL:
//       - magnitude product over 2*WIDTH bits; negated (two's complement, 2*WIDTH wide) if the operand signs differ.
//   - Signed DIV:
//       - quotient is truncated toward zero; quotient negated if the signs differ.
//       - remainder takes the dividend's sign.
//       - -2^(W-1) / -1 gives Result1=0x80000000 and Result2=0.
//   - DIV by zero: Result1 = all ones, Result2 = Operand1 (raw). Done is asserted in cycle 1, and Busy never rises.
//   - Reset asserted mid-operation aborts at once to IDLE with the reset values above; no Done is produced.
//   - Arithmetic is internal: 2*WIDTH-bit product/shift register and a WIDTH+1-bit subtractor. No overflow flags are exported.
// CONFIGURATION
//   MCYCLE_EARLY_TERM_EN
//     - defined: for MUL in RUN, if the remaining unshifted multiplier bits are all zero, the product is finalised that cycle.
//       The FSM goes to DONE in the next cycle, so latency = 1 + index of highest set multiplier bit + 1.
//       A multiplier of 0 yields Done in cycle 2. DIV latency is unchanged.
//     - undefined: fixed latency of WIDTH+1 cycles for every non-div-by-zero operation.
// TESTING
//   - Unsigned MUL 0xFFFFFFFF*0x00000002 (WA3E=5), op=2'b10:
//     -> Busy cycles 1-32; Done at cycle 33; Result1=0xFFFFFFFE, Result2=0x00000001, WA3R=5.
//   - Signed MUL -3*5, op=2'b00 -> Result1=0xFFFFFFF1, Result2=0xFFFFFFFF.
//   - Signed DIV -7/2, op=2'b01 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
//     Unsigned DIV 100/7 -> Result1=14, Result2=2.
//   - DIV 0x1234/0, op=2'b11 -> Done at cycle 1, Busy never 1; Result1=0xFFFFFFFF, Result2=0x00001234.
//   - Start held high through a whole operation -> the second op is accepted only in the IDLE cycle after Done.
//     Results of the first op are intact at their Done cycle.
//   - RESETn pulsed low at cycle 10 of a DIV -> Busy, Done and WA3R return to 0 immediately; no Done pulse follows.
//   - With MCYCLE_EARLY_TERM_EN: unsigned MUL 7*3 -> Done at cycle 3, Result1=21.
//     Without the macro, the same op gives Done at cycle 33.

Source files
------------

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative multiply/divide engine for the EX stage.
// One MUL or DIV is taken per Start pulse. The operation then runs for WIDTH
// cycles, one bit per cycle: shift-add for MUL, restoring shift-subtract for DIV.
// Signed operands are converted to magnitudes when the operation is accepted.
// The sign of each result is applied in the cycle that writes the result.
// Optional feature: define MCYCLE_EARLY_TERM_EN to enable early termination.
// With it, a MUL finishes as soon as the remaining multiplier bits are all zero.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [3:0]       WA3E,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       WA3R,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2
);

  localparam int CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    stIdle = 2'd0,
    stRun  = 2'd1,
    stDone = 2'd2
  } McState;

  McState state, nextState;

  logic [CntW-1:0]    counter;
  logic               opIsDiv;
  logic               negLo;
  logic               negRem;

  // Multiply working registers.
  // The multiplicand shifts left and the multiplier shifts right.
  logic [2*WIDTH-1:0] prodReg;
  logic [2*WIDTH-1:0] mcandReg;
  logic [WIDTH-1:0]   mplierReg;

  // Divide working registers.
  // The quotient register starts out holding the dividend.
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0]   remReg;
  logic [WIDTH-1:0]   quotReg;
  logic [WIDTH-1:0]   divisorReg;

  logic               opIsDivIn;
  logic               opSignedIn;
  logic               op1Neg;
  logic               op2Neg;
  logic [WIDTH-1:0]   op1Mag;
  logic [WIDTH-1:0]   op2Mag;
  logic               divByZero;

  logic [2*WIDTH-1:0] mulSum;
  logic [WIDTH:0]     divShifted;
  logic               divFits;
  logic [WIDTH-1:0]   divDiff;
  logic [WIDTH-1:0]   nextRem;
  logic [WIDTH-1:0]   nextQuot;
  logic               lastStep;
  logic               finishNow;

  logic [2*WIDTH-1:0] prodFinal;
  logic [WIDTH-1:0]   quotFinal;
  logic [WIDTH-1:0]   remFinal;

`ifdef MCYCLE_EARLY_TERM_EN
  logic               mulRemainingZero;
`endif

  // Decode the request and form operand magnitudes for acceptance in idle.
  always_comb begin
    opIsDivIn  = MCycleOp[0];
    opSignedIn = ~MCycleOp[1];
    op1Neg     = opSignedIn & Operand1[WIDTH-1];
    op2Neg     = opSignedIn & Operand2[WIDTH-1];
    op1Mag     = op1Neg ? (-Operand1) : Operand1;
    op2Mag     = op2Neg ? (-Operand2) : Operand2;
    divByZero  = opIsDivIn && (Operand2 == '0);
  end

  // Compute one iteration step for both engines and the signed final results.
  always_comb begin
    mulSum     = prodReg + (mplierReg[0] ? mcandReg : '0);
    divShifted = {remReg, quotReg[WIDTH-1]};
    divFits    = (divShifted >= {1'b0, divisorReg});
    divDiff    = divShifted[WIDTH-1:0] - divisorReg;
    nextRem    = divFits ? divDiff : divShifted[WIDTH-1:0];
    nextQuot   = {quotReg[WIDTH-2:0], divFits};
    lastStep   = (counter == CntW'(WIDTH - 1));
`ifdef MCYCLE_EARLY_TERM_EN
    mulRemainingZero = (mplierReg[WIDTH-1:1] == '0);
    finishNow  = lastStep | (~opIsDiv & mulRemainingZero);
`else
    finishNow  = lastStep;
`endif
    prodFinal  = negLo  ? (-mulSum)   : mulSum;
    quotFinal  = negLo  ? (-nextQuot) : nextQuot;
    remFinal   = negRem ? (-nextRem)  : nextRem;
  end

  // Hold the controller state; reset returns to idle immediately.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= stIdle;
    end else begin
      state <= nextState;
    end
  end

  // Select the next state and decode Busy and Done from the current state.
  always_comb begin
    nextState = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      stIdle: begin
        if (Start) begin
          nextState = divByZero ? stDone : stRun;
        end
      end
      stRun: begin
        Busy = 1'b1;
        if (finishNow) begin
          nextState = stDone;
        end
      end
      stDone: begin
        Done      = 1'b1;
        nextState = stIdle;
      end
      default: begin
        nextState = stIdle;
      end
    endcase
  end

  // Latch operands on acceptance, iterate while running, and load results.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      counter    <= '0;
      opIsDiv    <= 1'b0;
      negLo      <= 1'b0;
      negRem     <= 1'b0;
      prodReg    <= '0;
      mcandReg   <= '0;
      mplierReg  <= '0;
      remReg     <= '0;
      quotReg    <= '0;
      divisorReg <= '0;
      WA3R       <= '0;
      Result1    <= '0;
      Result2    <= '0;
    end else begin
      case (state)
        stIdle: begin
          if (Start) begin
            counter    <= '0;
            opIsDiv    <= opIsDivIn;
            negLo      <= op1Neg ^ op2Neg;
            negRem     <= op1Neg;
            prodReg    <= '0;
            mcandReg   <= {{WIDTH{1'b0}}, op1Mag};
            mplierReg  <= op2Mag;
            remReg     <= '0;
            quotReg    <= op1Mag;
            divisorReg <= op2Mag;
            WA3R       <= WA3E;
            if (divByZero) begin
              Result1 <= '1;
              Result2 <= Operand1;
            end
          end
        end
        stRun: begin
          counter <= counter + 1'b1;
          if (opIsDiv) begin
            remReg  <= nextRem;
            quotReg <= nextQuot;
          end else begin
            prodReg   <= mulSum;
            mcandReg  <= mcandReg << 1;
            mplierReg <= mplierReg >> 1;
          end
          if (finishNow) begin
            if (opIsDiv) begin
              Result1 <= quotFinal;
              Result2 <= remFinal;
            end else begin
              Result1 <= prodFinal[WIDTH-1:0];
              Result2 <= prodFinal[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed, table-driven bench for mcycle_unit.
// The expected latencies depend on MCYCLE_EARLY_TERM_EN.
module tb_mcycle_unit;

  logic        CLK;
  logic        RESETn;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [3:0]  WA3E;
  logic        Busy;
  logic        Done;
  logic [3:0]  WA3R;
  logic [31:0] Result1;
  logic [31:0] Result2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  wa;
    logic [31:0] r1;
    logic [31:0] r2;
    int          latDef;
    int          latEarly;
  } VecT;

  VecT vecs[14];

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .Start(Start),
    .MCycleOp(MCycleOp),
    .Operand1(Operand1),
    .Operand2(Operand2),
    .WA3E(WA3E),
    .Busy(Busy),
    .Done(Done),
    .WA3R(WA3R),
    .Result1(Result1),
    .Result2(Result2)
  );

  // Free-running clock with a 10-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one value and report any difference.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, then count cycles until Done.
  // The count is bounded; lat stays 0 if Done never arrives.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] wa, output int lat, output int busyCnt,
                               output logic [31:0] r1, output logic [31:0] r2, output logic [3:0] wr);
    @(negedge CLK);
    MCycleOp = op; Operand1 = a; Operand2 = b; WA3E = wa; Start = 1'b1;
    @(posedge CLK);
    lat = 0; busyCnt = 0; r1 = '0; r2 = '0; wr = '0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(negedge CLK);
      Start = 1'b0;
      Operand1 = ~a;
      Operand2 = b ^ 32'h0000_5A5A;
      WA3E = ~wa;
      if (Done) begin
        lat = k; r1 = Result1; r2 = Result2; wr = WA3R;
      end else if (Busy) begin
        busyCnt++;
      end
    end
  endtask

  initial begin
    int lat, busyCnt, expLat, doneCnt, busySeen;
    int firstDone, secondDone, expSecond;
    logic [31:0] r1, r2, firstR1, firstR2, secondR1, secondR2;
    logic [3:0]  wr, secondWr;

    //         op     a             b             wa    r1            r2            def early
    vecs[0]  = '{2'b10, 32'hFFFFFFFF, 32'h00000002, 4'd5, 32'hFFFFFFFE, 32'h00000001, 33, 3};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 4'd3, 32'hFFFFFFF1, 32'hFFFFFFFF, 33, 4};
    vecs[2]  = '{2'b01, 32'hFFFFFFF9, 32'h00000002, 4'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 33};
    vecs[3]  = '{2'b11, 32'd100,      32'd7,        4'd1, 32'd14,       32'd2,        33, 33};
    vecs[4]  = '{2'b11, 32'h00001234, 32'h00000000, 4'd9, 32'hFFFFFFFF, 32'h00001234, 1,  1};
    vecs[5]  = '{2'b10, 32'd7,        32'd3,        4'd2, 32'd21,       32'd0,        33, 3};
    vecs[6]  = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 4'd4, 32'h80000000, 32'h00000000, 33, 33};
    vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 4'd6, 32'h00000000, 32'h40000000, 33, 33};
    vecs[8]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8, 32'h00000001, 32'hFFFFFFFE, 33, 33};
    vecs[9]  = '{2'b00, 32'd12345,    32'd0,        4'd10, 32'd0,       32'd0,        33, 2};
    vecs[10] = '{2'b01, 32'd7,        32'hFFFFFFFE, 4'd11, 32'hFFFFFFFD, 32'h00000001, 33, 33};
    vecs[11] = '{2'b01, 32'hFFFFFFF8, 32'hFFFFFFFD, 4'd12, 32'h00000002, 32'hFFFFFFFE, 33, 33};
    vecs[12] = '{2'b11, 32'd5,        32'd9,        4'd13, 32'd0,       32'd5,        33, 33};
    vecs[13] = '{2'b01, 32'hFFFFFFFB, 32'h00000000, 4'd14, 32'hFFFFFFFF, 32'hFFFFFFFB, 1,  1};

    RESETn = 1'b1; Start = 1'b0; MCycleOp = '0; Operand1 = '0; Operand2 = '0; WA3E = '0;
    #2 RESETn = 1'b0;
    #1;
    checkOutput("reset Busy", 64'(Busy), 64'd0);
    checkOutput("reset Done", 64'(Done), 64'd0);
    checkOutput("reset WA3R", 64'(WA3R), 64'd0);
    checkOutput("reset Result1", 64'(Result1), 64'd0);
    checkOutput("reset Result2", 64'(Result2), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;

    for (int i = 0; i < 14; i++) begin
`ifdef MCYCLE_EARLY_TERM_EN
      expLat = vecs[i].latEarly;
`else
      expLat = vecs[i].latDef;
`endif
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wa, lat, busyCnt, r1, r2, wr);
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(expLat));
      checkOutput($sformatf("vec%0d busy cycles", i), 64'(busyCnt), 64'(expLat - 1));
      checkOutput($sformatf("vec%0d Result1", i), 64'(r1), 64'(vecs[i].r1));
      checkOutput($sformatf("vec%0d Result2", i), 64'(r2), 64'(vecs[i].r2));
      checkOutput($sformatf("vec%0d WA3R", i), 64'(wr), 64'(vecs[i].wa));
      @(negedge CLK);
      checkOutput($sformatf("vec%0d hold Result1", i), 64'(Result1), 64'(vecs[i].r1));
      checkOutput($sformatf("vec%0d idle Done", i), 64'(Done), 64'd0);
    end

    // Hold Start high through a DIV, with new operands presented right after acceptance.
    // The MUL behind it must be taken only in the idle cycle after Done.
    @(negedge CLK);
    MCycleOp = 2'b11; Operand1 = 32'd100; Operand2 = 32'd7; WA3E = 4'd2; Start = 1'b1;
    @(posedge CLK);
    firstDone = 0; secondDone = 0; doneCnt = 0;
    firstR1 = '0; firstR2 = '0; secondR1 = '0; secondR2 = '0; secondWr = '0;
`ifdef MCYCLE_EARLY_TERM_EN
    expSecond = 34 + 4;
`else
    expSecond = 34 + 33;
`endif
    for (int k = 1; k <= 120 && doneCnt < 2; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        MCycleOp = 2'b10; Operand1 = 32'd6; Operand2 = 32'd7; WA3E = 4'd4;
      end
      if (k == 10) checkOutput("held WA3R mid-run", 64'(WA3R), 64'd2);
      if (k == 34) checkOutput("held idle Busy", 64'(Busy), 64'd0);
      if (Done) begin
        doneCnt++;
        if (doneCnt == 1) begin
          firstDone = k; firstR1 = Result1; firstR2 = Result2;
        end else begin
          secondDone = k; secondR1 = Result1; secondR2 = Result2; secondWr = WA3R;
        end
      end
    end
    Start = 1'b0;
    checkOutput("held first Done cycle", 64'(firstDone), 64'd33);
    checkOutput("held first Result1", 64'(firstR1), 64'd14);
    checkOutput("held first Result2", 64'(firstR2), 64'd2);
    checkOutput("held second Done cycle", 64'(secondDone), 64'(expSecond));
    checkOutput("held second Result1", 64'(secondR1), 64'd42);
    checkOutput("held second Result2", 64'(secondR2), 64'd0);
    checkOutput("held second WA3R", 64'(secondWr), 64'd4);

    // Assert reset in cycle 10 of a DIV; the operation must abort with no Done afterwards.
    @(negedge CLK);
    @(negedge CLK);
    MCycleOp = 2'b11; Operand1 = 32'd1000; Operand2 = 32'd3; WA3E = 4'd6; Start = 1'b1;
    @(posedge CLK);
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      Start = 1'b0;
    end
    RESETn = 1'b0;
    #1;
    checkOutput("abort Busy", 64'(Busy), 64'd0);
    checkOutput("abort Done", 64'(Done), 64'd0);
    checkOutput("abort WA3R", 64'(WA3R), 64'd0);
    checkOutput("abort Result1", 64'(Result1), 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    doneCnt = 0; busySeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (Done) doneCnt++;
      if (Busy) busySeen++;
    end
    checkOutput("abort no Done", 64'(doneCnt), 64'd0);
    checkOutput("abort no Busy", 64'(busySeen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
